npu_requant: RTL and testbench
==============================

# npu_requant

Output requantization stage of the IMC-22 NPU. It accepts signed 32-bit dot-product results from the 16-MAC array and applies bias, fixed-point scale, rounding shift, optional ReLU, zero-point and INT8 saturation. It packs four INT8 activations into a 32-bit word for write-back to activation memory. This is the INT32→INT8 direction that complements the array's INT8→INT32 path, and it sits between the MAC array result and the activation buffer write port.

## Interface
Parameters:
- ACC_W, 32, accumulator input width (signed)
- MULT_W, 16, scale multiplier width (unsigned)
- SHIFT_W, 5, right-shift amount width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_acc/in_last valid
- in_ready  out  1  block accepts input this cycle
- in_acc  in  ACC_W  signed accumulator result
- in_last  in  1  last result of a vector; flushes a partial word
- cfg_bias  in  32  signed bias
- cfg_mult  in  MULT_W  unsigned scale multiplier
- cfg_shift  in  SHIFT_W  arithmetic right shift, 0..31
- cfg_zp  in  8  signed output zero point
- cfg_relu  in  1  clamp negative pre-zero-point values to 0
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts word
- out_data  out  32  packed INT8 results; first byte in [7:0]
- out_keep  out  4  valid byte lanes
- out_last  out  1  word holds the final byte of a vector
- busy  out  1  any stage valid, packer count ≠ 0, or out_valid

## Operation
- Handshake on both sides is valid/ready. A transfer happens on a rising edge with valid && ready. Once asserted, out_valid/out_data/out_keep/out_last hold stable until accepted.
- Global advance: adv = !(out_valid && !out_ready). in_ready = adv, a combinational path from out_ready. All pipeline stages and the packer update only when adv = 1.
- S1: sum = in_acc + cfg_bias, computed at 33 bits signed. No saturation.
- S2: prod = sum × {0, cfg_mult}, 50 bits signed.
- S3, round: if cfg_shift = 0, y = prod. Otherwise y = (prod + 2^(cfg_shift−1)) >>> cfg_shift, which is round-half-toward-+∞.
- S3, ReLU: if cfg_relu and y < 0, then y = 0.
- S3, output: z = y + sign-extended cfg_zp, saturated to [−128, 127]. The INT8 byte and its last flag are registered.
- Packer: a 3-byte hold register plus cnt (0..3).
  - On S3 byte with cnt < 3 and !last: store the byte at lane cnt, cnt++.
  - On S3 byte with cnt = 3 or last: load out_data with the held lanes plus this byte at lane cnt. Set out_keep = (1 << (cnt+1)) − 1 and out_last = last. Unused lanes = 0. cnt ← 0. out_valid ← 1.
- When adv = 1, out_valid clears on acceptance unless it is reloaded in the same cycle. Back-to-back words are sustained at one input per cycle.
- cfg_* must be held stable while busy = 1; changes while busy are undefined. Values are not sampled per-input.
- Simultaneous out accept and reload: the new word replaces the old one and out_valid stays 1.

## Timing
- Reset state: all stage valids 0, cnt = 0, hold register 0. out_valid = 0, out_data = 0, out_keep = 0, out_last = 0, busy = 0. in_ready = 1.
- Asserting rst_n low mid-operation discards all in-flight data immediately. No partial word is emitted after reset.
- Latency: the byte from an input accepted on edge k reaches the packer on edge k+3. A word completed by that byte is visible with out_valid = 1 after edge k+3, i.e. in the 4th cycle after the accept cycle.
- Throughput: 1 input/cycle while out_ready = 1.
- Stall: if out_valid && !out_ready, in_ready = 0 in the same cycle and the whole pipeline freezes. No data is lost or duplicated.

## Test plan
- Basic: bias=24, mult=1, shift=4, zp=0, relu=0; four inputs acc=1000 with last on the 4th → one word, out_data=0x40404040, keep=0xF, last=1, out_valid 4 cycles after the 4th accept.
- Rounding: mult=1, shift=4, bias=0; acc = −24, −25, 24, 8 → out_data=0x01_02_FE_FF, i.e. bytes −1, −2, 2, 1.
- Saturation and ReLU:
  - mult=65535, shift=0: acc=0x7FFFFFFF → 0x7F; acc=0x80000000 → 0x80.
  - relu=1, zp=5, mult=1, shift=0: acc=−100 → 0x05.
- Partial flush: three inputs with in_last on the 3rd → keep=0x7, last=1, out_data[31:24]=0. The next vector's first byte lands in lane 0.
- Backpressure: stream 16 inputs with out_ready low for 10 cycles mid-stream → in_ready drops while out_valid && !out_ready. Four words arrive in order with correct values and none repeated.
- Reset: assert rst_n low with 3 bytes packed and stages full → all outputs 0, busy=0. After release, a fresh 4-input vector produces exactly one correct word.

Source files
------------

// File: rtl/npu_requant_if.sv
// rtl/npu_requant_if.sv - valid/ready input and packed-output bundle for npu_requant
interface npu_requant_if #(
   parameter int ACC_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] in_acc;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [3:0]       out_keep;
   logic             out_last;

   modport slave (
      input  in_valid, in_acc, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

   modport master (
      output in_valid, in_acc, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/npu_requant.sv
// rtl/npu_requant.sv - INT32 accumulator to INT8 requantizer with bias, scale,
// rounding shift, ReLU, zero point, saturation and 4-byte word packing
module npu_requant #(
   parameter int ACC_W   = 32,
   parameter int MULT_W  = 16,
   parameter int SHIFT_W = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   npu_requant_if.slave              bus,
   input  logic signed [31:0]        i_cfg_bias,
   input  logic        [MULT_W-1:0]  i_cfg_mult,
   input  logic        [SHIFT_W-1:0] i_cfg_shift,
   input  logic signed [7:0]         i_cfg_zp,
   input  logic                      i_cfg_relu,
   output logic                      o_busy
);
   localparam int SUM_W  = ((ACC_W > 32) ? ACC_W : 32) + 1;
   localparam int PROD_W = SUM_W + MULT_W + 1;
   localparam logic signed [PROD_W-1:0] C_MAX8 = PROD_W'(127);
   localparam logic signed [PROD_W-1:0] C_MIN8 = PROD_W'(-128);

   logic                     w_adv;
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [PROD_W-1:0] w_sum_x;
   logic signed [PROD_W-1:0] w_mult_x;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [PROD_W-1:0] w_half;
   logic signed [PROD_W-1:0] w_rnd;
   logic signed [PROD_W-1:0] w_y;
   logic signed [PROD_W-1:0] w_zp_x;
   logic signed [PROD_W-1:0] w_z;
   logic        [7:0]        w_byte;
   logic                     w_flush;
   logic        [31:0]       w_word;
   logic        [3:0]        w_keep;

   logic                     r_s1_vld;
   logic                     r_s1_last;
   logic signed [SUM_W-1:0]  r_s1_sum;
   logic                     r_s2_vld;
   logic                     r_s2_last;
   logic signed [PROD_W-1:0] r_s2_prod;
   logic                     r_s3_vld;
   logic                     r_s3_last;
   logic        [7:0]        r_s3_byte;
   logic        [23:0]       r_hold;
   logic        [1:0]        r_cnt;
   logic                     r_out_valid;
   logic        [31:0]       r_out_data;
   logic        [3:0]        r_out_keep;
   logic                     r_out_last;

   // A held, unaccepted word freezes the whole pipeline including the input side.
   assign w_adv        = !(r_out_valid && !bus.out_ready);
   assign bus.in_ready = w_adv;

   assign w_sum    = {{(SUM_W-ACC_W){bus.in_acc[ACC_W-1]}}, bus.in_acc}
                   + {{(SUM_W-32){i_cfg_bias[31]}}, i_cfg_bias};
   assign w_sum_x  = {{(PROD_W-SUM_W){r_s1_sum[SUM_W-1]}}, r_s1_sum};
   assign w_mult_x = {{(PROD_W-MULT_W){1'b0}}, i_cfg_mult};
   assign w_prod   = w_sum_x * w_mult_x;

   // With shift = 0 the half-LSB term is zero and the shift is a no-op.
   always_comb begin
      w_half = '0;
      if (i_cfg_shift != '0) begin
         w_half[i_cfg_shift - 1'b1] = 1'b1;
      end
   end

   assign w_rnd  = (r_s2_prod + w_half) >>> i_cfg_shift;
   assign w_y    = (i_cfg_relu && w_rnd[PROD_W-1]) ? '0 : w_rnd;
   assign w_zp_x = {{(PROD_W-8){i_cfg_zp[7]}}, i_cfg_zp};
   assign w_z    = w_y + w_zp_x;

   always_comb begin
      w_byte = w_z[7:0];
      if (w_z > C_MAX8) begin
         w_byte = 8'h7F;
      end else if (w_z < C_MIN8) begin
         w_byte = 8'h80;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_sum  <= '0;
         r_s2_vld  <= 1'b0;
         r_s2_last <= 1'b0;
         r_s2_prod <= '0;
         r_s3_vld  <= 1'b0;
         r_s3_last <= 1'b0;
         r_s3_byte <= '0;
      end else if (w_adv) begin
         r_s1_vld  <= bus.in_valid;
         r_s1_last <= bus.in_last;
         r_s1_sum  <= w_sum;
         r_s2_vld  <= r_s1_vld;
         r_s2_last <= r_s1_last;
         r_s2_prod <= w_prod;
         r_s3_vld  <= r_s2_vld;
         r_s3_last <= r_s2_last;
         r_s3_byte <= w_byte;
      end
   end

   assign w_flush = (r_cnt == 2'd3) || r_s3_last;

   // Lanes above the incoming byte stay zero in a partial word.
   always_comb begin
      w_word = 32'h0;
      w_keep = 4'h0;
      case (r_cnt)
         2'd0: begin
            w_word = {24'h0, r_s3_byte};
            w_keep = 4'b0001;
         end
         2'd1: begin
            w_word = {16'h0, r_s3_byte, r_hold[7:0]};
            w_keep = 4'b0011;
         end
         2'd2: begin
            w_word = {8'h0, r_s3_byte, r_hold[15:0]};
            w_keep = 4'b0111;
         end
         default: begin
            w_word = {r_s3_byte, r_hold};
            w_keep = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= 1'b0;
         if (r_s3_vld) begin
            if (w_flush) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_word;
               r_out_keep  <= w_keep;
               r_out_last  <= r_s3_last;
               r_hold      <= '0;
               r_cnt       <= '0;
            end else begin
               case (r_cnt)
                  2'd0:    r_hold[7:0]   <= r_s3_byte;
                  2'd1:    r_hold[15:8]  <= r_s3_byte;
                  default: r_hold[23:16] <= r_s3_byte;
               endcase
               r_cnt <= r_cnt + 2'd1;
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_keep  = r_out_keep;
   assign bus.out_last  = r_out_last;

   assign o_busy = r_s1_vld || r_s2_vld || r_s3_vld || (r_cnt != 2'd0) || r_out_valid;
endmodule

// File: tb/tb_npu_requant.sv
// tb/tb_npu_requant.sv - directed self-checking bench for npu_requant
module tb_npu_requant;
   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [31:0] cfg_bias;
   logic        [15:0] cfg_mult;
   logic        [4:0]  cfg_shift;
   logic        [7:0]  cfg_zp;
   logic               cfg_relu;
   logic               busy;
   int                 n_checks = 0;
   int                 n_fail   = 0;
   logic        [36:0] q_out [$];

   always #5 clk = ~clk;

   npu_requant_if #(.ACC_W(32)) u_if ();

   npu_requant #(.ACC_W(32), .MULT_W(16), .SHIFT_W(5)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (u_if.slave),
      .i_cfg_bias  (cfg_bias),
      .i_cfg_mult  (cfg_mult),
      .i_cfg_shift (cfg_shift),
      .i_cfg_zp    (cfg_zp),
      .i_cfg_relu  (cfg_relu),
      .o_busy      (busy)
   );

   // A word seen valid and ready at the falling edge transfers on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && u_if.out_valid && u_if.out_ready) begin
         q_out.push_back({u_if.out_last, u_if.out_keep, u_if.out_data});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [31:0] acc, input logic last);
      int n = 0;
      u_if.in_valid = 1'b1;
      u_if.in_acc   = acc;
      u_if.in_last  = last;
      while (!u_if.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!u_if.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready=%b required 1", u_if.in_ready);
      end
      tick();
      u_if.in_valid = 1'b0;
      u_if.in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: busy=%b required 0", busy);
      end
   endtask

   task automatic get_word(output logic [36:0] w);
      int n = 0;
      while (q_out.size() == 0 && n < 200) begin
         tick();
         n++;
      end
      if (q_out.size() != 0) begin
         w = q_out.pop_front();
      end else begin
         w = '0;
         n_checks++;
         n_fail++;
         $display("FAIL word_timeout: queue size=%0d required >0", q_out.size());
      end
   endtask

   task automatic set_cfg(input logic [31:0] b, input logic [15:0] m, input logic [4:0] s,
                          input logic [7:0] z, input logic r);
      wait_idle();
      cfg_bias  = b;
      cfg_mult  = m;
      cfg_shift = s;
      cfg_zp    = z;
      cfg_relu  = r;
      q_out.delete();
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      u_if.in_valid = 1'b0;
      u_if.in_acc   = '0;
      u_if.in_last  = 1'b0;
      u_if.out_ready = 1'b1;
      cfg_bias = 0; cfg_mult = 16'd1; cfg_shift = 5'd0; cfg_zp = 8'd0; cfg_relu = 1'b0;
      #12;
      n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", u_if.out_valid); end
      n_checks++; if (u_if.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h required 00000000", u_if.out_data); end
      n_checks++; if (u_if.out_keep !== 4'h0) begin n_fail++; $display("FAIL rst_out_keep: got %h required 0", u_if.out_keep); end
      n_checks++; if (u_if.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b required 0", u_if.out_last); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
      n_checks++; if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", u_if.in_ready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      set_cfg(32'd24, 16'd1, 5'd4, 8'd0, 1'b0);
      for (int i = 0; i < 4; i++) send(32'd1000, i == 3);
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_checks++;
         if (u_if.out_valid !== (c == 3)) begin
            n_fail++;
            $display("FAIL basic_latency_c%0d: out_valid=%b required %b", c, u_if.out_valid, c == 3);
         end
      end
      n_checks++; if (u_if.out_data !== 32'h40404040) begin n_fail++; $display("FAIL basic_data: got %h required 40404040", u_if.out_data); end
      n_checks++; if (u_if.out_keep !== 4'hF) begin n_fail++; $display("FAIL basic_keep: got %h required f", u_if.out_keep); end
      n_checks++; if (u_if.out_last !== 1'b1) begin n_fail++; $display("FAIL basic_last: got %b required 1", u_if.out_last); end
   endtask

   task automatic test_rounding();
      logic [36:0] w;
      set_cfg(32'd0, 16'd1, 5'd4, 8'd0, 1'b0);
      send(-32'sd24, 1'b0);
      send(-32'sd25, 1'b0);
      send(32'd24, 1'b0);
      send(32'd8, 1'b1);
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'hF, 32'h0102FEFF}) begin n_fail++; $display("FAIL round_word: got %h required %h", w, {1'b1, 4'hF, 32'h0102FEFF}); end
   endtask

   task automatic test_sat_relu();
      logic [36:0] w;
      set_cfg(32'd0, 16'd65535, 5'd0, 8'd0, 1'b0);
      send(32'h7FFFFFFF, 1'b0);
      send(32'h80000000, 1'b1);
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'h3, 32'h0000807F}) begin n_fail++; $display("FAIL sat_word: got %h required %h", w, {1'b1, 4'h3, 32'h0000807F}); end
      set_cfg(32'd0, 16'd1, 5'd0, 8'd5, 1'b1);
      send(-32'sd100, 1'b0);
      send(32'd100, 1'b1);
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'h3, 32'h00006905}) begin n_fail++; $display("FAIL relu_word: got %h required %h", w, {1'b1, 4'h3, 32'h00006905}); end
      set_cfg(32'd0, 16'd1, 5'd0, 8'h80, 1'b0);
      send(-32'sd100, 1'b0);
      send(32'd200, 1'b1);
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'h3, 32'h00004880}) begin n_fail++; $display("FAIL zp_neg_word: got %h required %h", w, {1'b1, 4'h3, 32'h00004880}); end
   endtask

   task automatic test_partial_flush();
      logic [36:0] w;
      set_cfg(32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b1);
      send(32'd4, 1'b1);
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'h7, 32'h00030201}) begin n_fail++; $display("FAIL flush_word: got %h required %h", w, {1'b1, 4'h7, 32'h00030201}); end
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'h1, 32'h00000004}) begin n_fail++; $display("FAIL flush_next_lane0: got %h required %h", w, {1'b1, 4'h1, 32'h00000004}); end
   endtask

   task automatic test_back_to_back();
      logic [36:0] w;
      logic [31:0] exp_data;
      int          n_stall = 0;
      set_cfg(32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
      fork
         begin
            for (int i = 0; i < 16; i++) send(32'(i + 1), i == 15);
         end
         begin
            repeat (5) @(posedge clk);
            #1 u_if.out_ready = 1'b0;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               if (u_if.out_valid && !u_if.out_ready) begin
                  n_stall++;
                  n_checks++;
                  if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b required 0", u_if.in_ready); end
               end
            end
            @(posedge clk);
            #1 u_if.out_ready = 1'b1;
         end
      join
      n_checks++; if (n_stall == 0) begin n_fail++; $display("FAIL stall_seen: stalled cycles=%0d required >0", n_stall); end
      for (int k = 0; k < 4; k++) begin
         exp_data = {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
         get_word(w);
         n_checks++;
         if (w !== {k == 3, 4'hF, exp_data}) begin
            n_fail++;
            $display("FAIL b2b_word%0d: got %h required %h", k, w, {k == 3, 4'hF, exp_data});
         end
      end
      wait_idle();
      n_checks++; if (q_out.size() != 0) begin n_fail++; $display("FAIL b2b_extra_words: got %0d required 0", q_out.size()); end
   endtask

   task automatic test_reset_mid();
      logic [36:0] w;
      set_cfg(32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
      for (int i = 0; i < 6; i++) send(32'(i + 7), 1'b0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b required 1", busy); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", u_if.out_valid); end
      n_checks++; if (u_if.out_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h required 00000000", u_if.out_data); end
      n_checks++; if (u_if.out_keep !== 4'h0) begin n_fail++; $display("FAIL mid_rst_keep: got %h required 0", u_if.out_keep); end
      n_checks++; if (u_if.out_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last: got %b required 0", u_if.out_last); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
      tick();
      tick();
      rst_n = 1'b1;
      q_out.delete();
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      send(32'd30, 1'b0);
      send(32'd40, 1'b1);
      wait_idle();
      n_checks++; if (q_out.size() != 1) begin n_fail++; $display("FAIL mid_word_count: got %0d required 1", q_out.size()); end
      get_word(w);
      n_checks++; if (w !== {1'b1, 4'hF, 32'h281E140A}) begin n_fail++; $display("FAIL mid_word: got %h required %h", w, {1'b1, 4'hF, 32'h281E140A}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_sat_relu();
      test_partial_flush();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
